count_scan4: RTL and testbench



---
 rtl/count_scan4.sv | 102 ++++++++++
 tb/tb_count_scan4.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/count_scan4.sv
// rtl/count_scan4.sv - four-digit BCD up/down counter with multiplexed digit scanner
// Prescaled count ticks, leading-zero blanking via active-low digit enables.
module count_scan4 #(
    parameter int PRESCALE = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        UP,
    input  logic        CLR,
    output logic [3:0]  CNT,
    output logic [3:0]  DIGIT,
    output logic        CARRY,
    output logic [15:0] VALUE
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [SW-1:0] scan;
    logic [1:0]    sel;
    logic          tick;
    logic          wrap;
    logic [15:0]   value_next;
    logic [3:0]    blank;

    // Ripple a decimal carry (or borrow) from the ones digit upward.
    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        tick       = EN && (presc == PRE_LAST);
        wrap       = UP ? (VALUE == 16'h9999) : (VALUE == 16'h0000);
        value_next = bcd_step(VALUE, UP);
        blank[0]   = 1'b0;
        blank[1]   = (VALUE[15:4]  == 12'h000);
        blank[2]   = (VALUE[15:8]  == 8'h00);
        blank[3]   = (VALUE[15:12] == 4'h0);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc <= '0;
            VALUE <= 16'h0000;
            CARRY <= 1'b0;
        end else if (CLR) begin
            presc <= '0;
            VALUE <= 16'h0000;
            CARRY <= 1'b0;
        end else begin
            if (EN) presc <= tick ? '0 : presc + PW'(1);
            if (tick) VALUE <= value_next;
            CARRY <= tick && wrap;
        end
    end

    // Scanner free-runs; outputs sample the pre-edge sel and VALUE together.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan  <= '0;
            sel   <= 2'd0;
            CNT   <= 4'h0;
            DIGIT <= 4'b1111;
        end else begin
            if (scan == SCAN_LAST) begin
                scan <= '0;
                sel  <= sel + 2'd1;
            end else begin
                scan <= scan + SW'(1);
            end
            CNT   <= VALUE[4*sel +: 4];
            DIGIT <= blank[sel] ? 4'b1111 : ~(4'b0001 << sel);
        end
    end

endmodule

// File: tb/tb_count_scan4.sv
// tb/tb_count_scan4.sv - directed self-checking bench for count_scan4
module tb_count_scan4;

    logic        clk;
    logic        rst_a, en_a, up_a, clr_a;
    logic [3:0]  cnt_a, digit_a;
    logic        carry_a;
    logic [15:0] value_a;
    logic        rst_b, en_b, up_b, clr_b;
    logic [3:0]  cnt_b, digit_b;
    logic        carry_b;
    logic [15:0] value_b;

    int tests = 0;
    int fails = 0;

    count_scan4 #(.PRESCALE(1), .SCAN_DIV(2)) dut_a (
        .CLK(clk), .RST(rst_a), .EN(en_a), .UP(up_a), .CLR(clr_a),
        .CNT(cnt_a), .DIGIT(digit_a), .CARRY(carry_a), .VALUE(value_a)
    );

    count_scan4 #(.PRESCALE(4), .SCAN_DIV(3)) dut_b (
        .CLK(clk), .RST(rst_b), .EN(en_b), .UP(up_b), .CLR(clr_b),
        .CNT(cnt_b), .DIGIT(digit_b), .CARRY(carry_b), .VALUE(value_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Align to the start of the ones-digit slot, then check four 2-cycle slots.
    task automatic scan_check(input string tag, input logic [15:0] dexp, input logic [15:0] cexp);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        prev  = digit_a;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1);
            if (digit_a == 4'b1110 && prev != 4'b1110) found = 1'b1;
            else prev = digit_a;
        end
        check({tag, "_sync"}, {15'd0, found}, 16'd1);
        if (found) begin
            for (int k = 0; k < 8; k++) begin
                check({tag, "_digit"}, {12'd0, digit_a}, {12'd0, dexp[4*(k/2) +: 4]});
                check({tag, "_cnt"},   {12'd0, cnt_a},   {12'd0, cexp[4*(k/2) +: 4]});
                step(1);
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; clr_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; clr_b = 1'b0;
        #3;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("rst_value", value_a, 16'h0000);
        check("rst_digit", {12'd0, digit_a}, 16'h000f);
        check("rst_cnt",   {12'd0, cnt_a},   16'h0000);
        check("rst_carry", {15'd0, carry_a}, 16'h0000);
        check("rst_value_b", value_b, 16'h0000);
        step(2);
        rst_a = 1'b1;
        step(3);
        check("en_off_hold", value_a, 16'h0000);

        // async reset mid-count
        en_a = 1'b1;
        step(42);
        check("count_42", value_a, 16'h0042);
        rst_a = 1'b0;
        #1;
        check("async_value", value_a, 16'h0000);
        check("async_digit", {12'd0, digit_a}, 16'h000f);
        check("async_cnt",   {12'd0, cnt_a},   16'h0000);
        check("async_carry", {15'd0, carry_a}, 16'h0000);
        step(1);
        rst_a = 1'b1;

        // decimal carry boundaries
        step(9);
        check("up_0009", value_a, 16'h0009);
        step(1);
        check("up_0010", value_a, 16'h0010);
        step(89);
        check("up_0099", value_a, 16'h0099);
        step(1);
        check("up_0100", value_a, 16'h0100);
        check("up_carry0", {15'd0, carry_a}, 16'h0000);
        step(5);
        check("up_0105", value_a, 16'h0105);
        en_a = 1'b0;
        scan_check("scan_0105", {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {4'h0, 4'h1, 4'h0, 4'h5});

        // wrap up
        en_a = 1'b1;
        step(9894);
        check("up_9999", value_a, 16'h9999);
        check("up_9999_carry", {15'd0, carry_a}, 16'h0000);
        step(1);
        check("wrap_value", value_a, 16'h0000);
        check("wrap_carry", {15'd0, carry_a}, 16'h0001);
        step(1);
        check("wrap_after", value_a, 16'h0001);
        check("wrap_carry_once", {15'd0, carry_a}, 16'h0000);

        en_a = 1'b0;
        rst_a = 1'b0;
        step(1);
        rst_a = 1'b1;
        scan_check("scan_0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, 16'h0000);

        // down count and borrow, PRESCALE=4
        en_b = 1'b1; up_b = 1'b0;
        rst_b = 1'b1;
        step(3);
        check("down_pre", value_b, 16'h0000);
        step(1);
        check("down_9999", value_b, 16'h9999);
        check("down_carry", {15'd0, carry_b}, 16'h0001);
        step(1);
        check("down_carry_once", {15'd0, carry_b}, 16'h0000);
        step(2);
        check("down_hold", value_b, 16'h9999);
        step(1);
        check("down_9998", value_b, 16'h9998);
        check("down_9998_carry", {15'd0, carry_b}, 16'h0000);

        // EN gating across a gap
        rst_b = 1'b0;
        step(1);
        rst_b = 1'b1; up_b = 1'b1; en_b = 1'b1;
        step(2);
        en_b = 1'b0;
        step(5);
        check("gap_hold", value_b, 16'h0000);
        en_b = 1'b1;
        step(1);
        check("gap_3rd", value_b, 16'h0000);
        step(1);
        check("gap_4th", value_b, 16'h0001);

        // CLR on a wrap tick
        rst_b = 1'b0;
        step(1);
        rst_b = 1'b1; up_b = 1'b0;
        step(4);
        check("clr_setup", value_b, 16'h9999);
        up_b = 1'b1;
        step(3);
        check("clr_pretick", value_b, 16'h9999);
        clr_b = 1'b1;
        step(1);
        check("clr_value", value_b, 16'h0000);
        check("clr_carry", {15'd0, carry_b}, 16'h0000);
        clr_b = 1'b0;
        step(3);
        check("clr_presc_value", value_b, 16'h0000);
        check("clr_presc_carry", {15'd0, carry_b}, 16'h0000);
        step(1);
        check("clr_next_tick", value_b, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
